fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch stage in front of a single-cycle core. It drives a
// synchronous instruction memory with a read latency of one cycle. Returned
// words go into a small show-ahead prefetch FIFO. The core takes each
// instruction together with its PC through a valid/ready handshake. A redirect
// pulse flushes the FIFO, drops the response that is still in flight and
// restarts fetch at the new PC.
//
// Parameters
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   ADDR_W    IMEM word-address width
//   RESET_PC  first fetch PC after reset (word aligned)
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   imem_req     fetch request issued this cycle
//   imem_addr    word address of the request (fpc[ADDR_W+1:2])
//   imem_rdata   instruction word, valid one cycle after imem_req
//   redirect     single-cycle flush/restart pulse
//   redirect_pc  restart PC, bits [1:0] ignored
//   inst_valid   FIFO head holds a valid instruction
//   inst         head instruction word
//   inst_pc      PC of the head instruction
//   inst_ready   core accepts the head this cycle
//
// Optional build macro: FETCH_STATS_EN
//   When defined, the block adds two 32-bit wrapping counters:
//   stat_fetched   counts FIFO pushes
//   stat_squashed  counts responses and FIFO entries discarded by redirects
// ============================================================================
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_squashed
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      r_fpc;
    logic             r_infl;
    logic [31:0]      r_infl_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [31:0]      r_mem_inst [DEPTH];
    logic [31:0]      r_mem_pc   [DEPTH];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [CNT_W:0]   w_level;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_redirect_pc;
    logic             w_unused_ok;

    // Reserved slots: the buffered entries plus the response still on its
    // way. A request is issued only when a slot is guaranteed, so the FIFO
    // cannot overflow and no back-pressure on IMEM is needed.
    assign w_level = {1'b0, r_count} + {{CNT_W{1'b0}}, r_infl};

    // RST is included so that no request is seen while reset is held, even
    // though the empty state alone would otherwise allow an issue.
    assign w_issue = !RST && !redirect && (w_level < (CNT_W+1)'(DEPTH));

    // Redirect wins: the response and the pop in that cycle are both dropped.
    assign w_push  = r_infl && !redirect;
    assign w_pop   = inst_valid && inst_ready && !redirect;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused_ok   = &{1'b0, redirect_pc[1:0]};

    assign imem_req   = w_issue;
    assign imem_addr  = r_fpc[ADDR_W+1:2];
    assign inst_valid = (r_count != '0);
    assign inst       = r_mem_inst[r_head];
    assign inst_pc    = r_mem_pc[r_head];

    // ------------------------------------------------------------------
    // Fetch PC and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fpc     <= RESET_PC;
            r_infl    <= 1'b0;
            r_infl_pc <= 32'h0;
        end else if (redirect) begin
            r_fpc  <= w_redirect_pc;
            r_infl <= 1'b0;
        end else begin
            r_infl <= w_issue;
            if (w_issue) begin
                r_infl_pc <= r_fpc;
                r_fpc     <= r_fpc + 32'd4;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: each entry has its own write enable decoded from the
    // tail pointer. Entries clear on reset so the head reads as zero.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_mem_inst[gi] <= 32'h0;
                    r_mem_pc[gi]   <= 32'h0;
                end else if (w_push && (r_tail == PTR_W'(gi))) begin
                    r_mem_inst[gi] <= imem_rdata;
                    r_mem_pc[gi]   <= r_infl_pc;
                end
            end
        end
    endgenerate

`ifdef FETCH_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (wrap on overflow)
    // ------------------------------------------------------------------
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_squashed;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stat_fetched  <= 32'h0;
            r_stat_squashed <= 32'h0;
        end else begin
            if (w_push) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            // A redirect throws away every buffered entry plus the response
            // arriving in the same cycle.
            if (redirect) begin
                r_stat_squashed <= r_stat_squashed + 32'(r_count) + 32'(r_infl);
            end
        end
    end

    assign stat_fetched  = r_stat_fetched;
    assign stat_squashed = r_stat_squashed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int ADDR_W = 10;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = 32'h0;
    logic              redirect = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              inst_ready = 1'b0;
`ifdef FETCH_STATS_EN
    logic [31:0]       stat_fetched;
    logic [31:0]       stat_squashed;
`endif

    always #5 CLK = ~CLK;

    fetch_unit #(
        .DEPTH   (4),
        .ADDR_W  (ADDR_W),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_squashed(stat_squashed)
`endif
    );

    // IMEM model: one-cycle latency, word = byte address (addr*4).
    // Returns a marker when no request was made so stray pushes show up.
    always @(posedge CLK) begin
        if (imem_req)
            imem_rdata <= {20'h0, imem_addr, 2'b00};
        else
            imem_rdata <= 32'hDEAD_BEEF;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              rd;
        logic [31:0]       rpc;
        logic              rdy;
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              val;
        logic [31:0]       pc;
        logic [31:0]       ins;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic req, input logic [ADDR_W-1:0] addr,
                       input logic val, input logic [31:0] pc, input logic [31:0] ins);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.req = req;
        v.addr = addr; v.val = val; v.pc = pc; v.ins = ins;
        vq.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // Cycle-by-cycle vectors from reset release (cycle 0).
        // Stall phase: inst_ready low for 10 cycles.
        add(0, 0, 0, 1, 10'h000, 0, 32'h0, 32'h0);        // c0
        add(0, 0, 0, 1, 10'h001, 0, 32'h0, 32'h0);        // c1
        add(0, 0, 0, 1, 10'h002, 1, 32'h0, 32'h0);        // c2
        add(0, 0, 0, 1, 10'h003, 1, 32'h0, 32'h0);        // c3
        for (int c = 4; c < 10; c++)
            add(0, 0, 0, 0, 10'h004, 1, 32'h0, 32'h0);    // c4..c9 full, no issue
        // Release: 0x0..0x18 with no gap
        add(0, 0, 1, 0, 10'h004, 1, 32'h0,  32'h0);       // c10
        add(0, 0, 1, 1, 10'h004, 1, 32'h4,  32'h4);       // c11
        add(0, 0, 1, 1, 10'h005, 1, 32'h8,  32'h8);       // c12
        add(0, 0, 1, 1, 10'h006, 1, 32'hC,  32'hC);       // c13
        add(0, 0, 1, 1, 10'h007, 1, 32'h10, 32'h10);      // c14
        add(0, 0, 1, 1, 10'h008, 1, 32'h14, 32'h14);      // c15
        add(0, 0, 1, 1, 10'h009, 1, 32'h18, 32'h18);      // c16
        add(0, 0, 0, 1, 10'h00A, 1, 32'h1C, 32'h1C);      // c17 -> 3 buffered, 1 in flight
        add(1, 32'h103, 0, 0, 10'h00B, 1, 32'h1C, 32'h1C);// c18 redirect
        add(0, 0, 1, 1, 10'h040, 0, 32'h0, 32'h0);        // c19 R+1
        add(0, 0, 1, 1, 10'h041, 0, 32'h0, 32'h0);        // c20
        add(0, 0, 1, 1, 10'h042, 1, 32'h100, 32'h100);    // c21 R+3
        add(0, 0, 1, 1, 10'h043, 1, 32'h104, 32'h104);    // c22
        // Redirect together with a pop and a response
        add(1, 32'h200, 1, 0, 10'h000, 1, 32'h108, 32'h108); // c23
        add(0, 0, 1, 1, 10'h080, 0, 32'h0, 32'h0);        // c24
        add(0, 0, 1, 1, 10'h081, 0, 32'h0, 32'h0);        // c25
        add(0, 0, 1, 1, 10'h082, 1, 32'h200, 32'h200);    // c26
        // Back-to-back redirects, last wins
        add(1, 32'h300, 1, 0, 10'h000, 1, 32'h204, 32'h204); // c27
        add(1, 32'h401, 1, 0, 10'h000, 0, 32'h0, 32'h0);  // c28
        add(0, 0, 1, 1, 10'h100, 0, 32'h0, 32'h0);        // c29
        add(0, 0, 1, 1, 10'h101, 0, 32'h0, 32'h0);        // c30
        add(0, 0, 1, 1, 10'h102, 1, 32'h400, 32'h400);    // c31
        // Address wrap at the top of IMEM
        add(1, 32'hFFE, 1, 0, 10'h000, 1, 32'h404, 32'h404); // c32
        add(0, 0, 1, 1, 10'h3FF, 0, 32'h0, 32'h0);        // c33
        add(0, 0, 1, 1, 10'h000, 0, 32'h0, 32'h0);        // c34
        add(0, 0, 1, 1, 10'h001, 1, 32'hFFC,  32'hFFC);   // c35
        add(0, 0, 1, 1, 10'h002, 1, 32'h1000, 32'h0);     // c36
        add(0, 0, 1, 1, 10'h003, 1, 32'h1004, 32'h4);     // c37

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset imem_req",   {31'h0, imem_req},   32'h0);
        chk("reset inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("reset inst",       inst,                32'h0);
        chk("reset inst_pc",    inst_pc,             32'h0);
`ifdef FETCH_STATS_EN
        chk("reset stat_fetched",  stat_fetched,  32'h0);
        chk("reset stat_squashed", stat_squashed, 32'h0);
`endif
        @(posedge CLK);
        #1 RST = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            redirect    = vq[i].rd;
            redirect_pc = vq[i].rpc;
            inst_ready  = vq[i].rdy;
            @(negedge CLK);
            $display("c%0d: redirect=%b ready=%b req=%b addr=%h valid=%b pc=%h inst=%h",
                     i, redirect, inst_ready, imem_req, imem_addr, inst_valid, inst_pc, inst);
            chk($sformatf("c%0d imem_req", i), {31'h0, imem_req}, {31'h0, vq[i].req});
            if (vq[i].req)
                chk($sformatf("c%0d imem_addr", i), {22'h0, imem_addr}, {22'h0, vq[i].addr});
            chk($sformatf("c%0d inst_valid", i), {31'h0, inst_valid}, {31'h0, vq[i].val});
            if (vq[i].val) begin
                chk($sformatf("c%0d inst_pc", i), inst_pc, vq[i].pc);
                chk($sformatf("c%0d inst", i),    inst,    vq[i].ins);
            end
            @(posedge CLK);
            #1;
        end
        redirect    = 1'b0;
        redirect_pc = 32'h0;

`ifdef FETCH_STATS_EN
        chk("stat_squashed after redirects", stat_squashed, 32'd10);
`endif

        // Fill the FIFO, then hit RST asynchronously mid-cycle.
        inst_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLK);
            if (!imem_req)
                found = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        chk("stall imem_req drop within bound", {31'h0, found}, 32'h1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        $display("full: req=%b valid=%b pc=%h", imem_req, inst_valid, inst_pc);
        chk("full inst_valid", {31'h0, inst_valid}, 32'h1);
        chk("full imem_req",   {31'h0, imem_req},   32'h0);
        #2 RST = 1'b1;
        #1;
        $display("async reset: req=%b valid=%b pc=%h inst=%h", imem_req, inst_valid, inst_pc, inst);
        chk("async rst inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("async rst imem_req",   {31'h0, imem_req},   32'h0);
        chk("async rst inst_pc",    inst_pc,             32'h0);
        chk("async rst inst",       inst,                32'h0);
`ifdef FETCH_STATS_EN
        chk("async rst stat_squashed", stat_squashed, 32'h0);
`endif
        @(posedge CLK);
        #1 RST = 1'b0;
        inst_ready = 1'b1;
        @(negedge CLK);
        $display("restart c0: req=%b addr=%h valid=%b", imem_req, imem_addr, inst_valid);
        chk("restart c0 imem_req",  {31'h0, imem_req},   32'h1);
        chk("restart c0 imem_addr", {22'h0, imem_addr},  32'h0);
        chk("restart c0 inst_valid",{31'h0, inst_valid}, 32'h0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        $display("restart c1: req=%b addr=%h valid=%b", imem_req, imem_addr, inst_valid);
        chk("restart c1 imem_addr", {22'h0, imem_addr},  32'h1);
        chk("restart c1 inst_valid",{31'h0, inst_valid}, 32'h0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        $display("restart c2: valid=%b pc=%h inst=%h", inst_valid, inst_pc, inst);
        chk("restart c2 inst_valid", {31'h0, inst_valid}, 32'h1);
        chk("restart c2 inst_pc",    inst_pc,             32'h0);
        chk("restart c2 inst",       inst,                32'h0);
`ifdef FETCH_STATS_EN
        chk("restart c2 stat_fetched", stat_fetched, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
